// File: rtl/des_subkey_sequencer.sv
// -----------------------------------------------------------------------------
// des_subkey_sequencer
//
// Sequential DES key schedule. One 64-bit key goes in and the 16 48-bit round
// subkeys come out, one per valid/ready handshake. The order is K1..K16 for
// encrypt and K16..K1 for decrypt. The block applies PC-1, then rotates C and D
// per round (left for encrypt, right for decrypt), then applies PC-2. It sits
// between the key register and the pipelined round datapath.
//
// Parameters
//   OUT_REG       1: subkey comes from a registered PC-2 stage (first valid two
//                    cycles after start, then one subkey per cycle)
//                 0: subkey is PC-2 taken combinationally from the C/D register
//                    (first valid one cycle after start)
//
// Ports
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   key_in        in   64  DES key; key_in[63] is FIPS bit 1; the parity bits
//                          (bit 8 of each byte) are dropped by PC-1
//   decrypt       in   1   sampled with start; 1 = emit K16..K1
//   start         in   1   request a new schedule; accepted only in IDLE
//   subkey        out  48  current subkey; subkey[47] is PC-2 output bit 1
//   round_idx     out  4   round of the current subkey, 0..15 = K1..K16
//   subkey_valid  out  1   subkey and round_idx are valid
//   subkey_ready  in   1   subkey is consumed when subkey_valid && subkey_ready
//   busy          out  1   high from the accepted start until done
//   done          out  1   one-cycle pulse after the 16th handshake
//   parity_err    out  1   key parity failure flag (see below)
//
// Optional feature (macro KEY_PARITY_CHECK_EN)
//   Defined:   on start in IDLE every key byte must have odd parity. On failure
//              parity_err is set, the start is rejected and the FSM stays in
//              IDLE. parity_err stays set until the next accepted start or
//              reset.
//   Undefined: parity is not checked and parity_err is tied to 0.
// -----------------------------------------------------------------------------
module des_subkey_sequencer #(
  parameter int OUT_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        start,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  // Tables are 1-based FIPS bit numbers, entry 0 is output bit 1.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } state_e;

  // FIPS bit n of the key lives at key_in[64-n]; output bit i+1 of PC-1 is
  // placed at cd[55-i], so C = cd[55:28] and D = cd[27:0].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
    end
    return r;
  endfunction

  // CD bit n (1-based) lives at cd[56-n].
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
    end
    return r;
  endfunction

  // Shift amount for a 0-based round: 1 for rounds 1, 2, 9, 16, else 2.
  function automatic logic shift_two(input logic [3:0] idx);
    return !((idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15));
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // C0/D0 -> C1/D1 for encrypt: one left rotation of each half.
  function automatic logic [55:0] first_enc(input logic [55:0] cd);
    return {rol28(cd[55:28], 1'b0), rol28(cd[27:0], 1'b0)};
  endfunction

  // Advance C/D from the round at idx to the next round in emit order.
  // Encrypt K(r+1) rotates left by s[r+1]; decrypt K(r-1) rotates right by s[r].
  function automatic logic [55:0] step_cd(input logic [55:0] cd,
                                          input logic        dec,
                                          input logic [3:0]  idx);
    logic [55:0] r;
    logic        two;
    if (dec) begin
      two = shift_two(idx);
      r   = {ror28(cd[55:28], two), ror28(cd[27:0], two)};
    end else begin
      two = shift_two(idx + 4'd1);
      r   = {rol28(cd[55:28], two), rol28(cd[27:0], two)};
    end
    return r;
  endfunction

  state_e      state;
  logic        dir_p0;      // latched decrypt
  logic [55:0] cd_p0;       // C/D of the current (or about-to-load) round
  logic [47:0] subkey_p1;   // registered PC-2 output
  logic [3:0]  idx_p1;
  logic        vld_p1;
  logic        busy_q;
  logic        done_q;

  logic [55:0] pc1_key;
  logic [55:0] cd_load;
  logic [55:0] cd_fast;
  logic [55:0] cd_next;
  logic        handshake;
  logic        last_round;
  logic        key_ok;
  logic        accept;

  assign pc1_key    = pc1(key_in);
  // Decrypt starts at K16, whose C16/D16 equal C0/D0 (total rotation is 28).
  assign cd_load    = dir_p0  ? cd_p0   : first_enc(cd_p0);
  assign cd_fast    = decrypt ? pc1_key : first_enc(pc1_key);
  assign cd_next    = step_cd(cd_p0, dir_p0, idx_p1);
  assign handshake  = vld_p1 && subkey_ready;
  assign last_round = dir_p0 ? (idx_p1 == 4'd0) : (idx_p1 == 4'd15);
  assign accept     = (state == IDLE) && start && key_ok;

`ifdef KEY_PARITY_CHECK_EN
  logic par_err_q;

  // Every byte of a valid DES key has odd parity.
  assign key_ok = (^key_in[63:56]) && (^key_in[55:48]) &&
                  (^key_in[47:40]) && (^key_in[39:32]) &&
                  (^key_in[31:24]) && (^key_in[23:16]) &&
                  (^key_in[15:8])  && (^key_in[7:0]);

  // A rejected start sets the flag; only an accepted start clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      par_err_q <= !key_ok;
    end
  end

  assign parity_err = par_err_q;
`else
  assign key_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dir_p0    <= 1'b0;
      cd_p0     <= '0;
      subkey_p1 <= '0;
      idx_p1    <= '0;
      vld_p1    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        // Stage p0: latch PC-1 of the key and the direction.
        IDLE: begin
          if (accept) begin
            dir_p0 <= decrypt;
            busy_q <= 1'b1;
            if (OUT_REG != 0) begin
              cd_p0 <= pc1_key;
              state <= LOAD;
            end else begin
              // Combinational PC-2: C/D must already hold the first round.
              cd_p0  <= cd_fast;
              idx_p1 <= decrypt ? 4'd15 : 4'd0;
              vld_p1 <= 1'b1;
              state  <= EMIT;
            end
          end
        end

        // Stage p1: first-round C/D and its registered PC-2.
        LOAD: begin
          cd_p0     <= cd_load;
          subkey_p1 <= pc2(cd_load);
          idx_p1    <= dir_p0 ? 4'd15 : 4'd0;
          vld_p1    <= 1'b1;
          state     <= EMIT;
        end

        EMIT: begin
          if (handshake) begin
            if (last_round) begin
              vld_p1 <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= FINISH;
            end else begin
              cd_p0     <= cd_next;
              subkey_p1 <= pc2(cd_next);
              idx_p1    <= dir_p0 ? (idx_p1 - 4'd1) : (idx_p1 + 4'd1);
            end
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign subkey       = (OUT_REG != 0) ? subkey_p1 : pc2(cd_p0);
  assign round_idx    = idx_p1;
  assign subkey_valid = vld_p1;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_subkey_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des_subkey_sequencer
//
// Directed bench for des_subkey_sequencer (default OUT_REG = 1). Expected
// subkeys are the FIPS worked example for key 133457799BBCDFF1.
// -----------------------------------------------------------------------------
module tb_des_subkey_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] key_in;
  logic        decrypt;
  logic        start;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        busy;
  logic        done;
  logic        parity_err;

  always #5 clk = ~clk;

  des_subkey_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .key_in      (key_in),
    .decrypt     (decrypt),
    .start       (start),
    .subkey      (subkey),
    .round_idx   (round_idx),
    .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready),
    .busy        (busy),
    .done        (done),
    .parity_err  (parity_err)
  );

  localparam logic [63:0] KEY_T1     = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BADPAR = 64'h123457799BBCDFF1;

  localparam logic [47:0] EXP_K [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  int total = 0;
  int bad   = 0;

  // Captured by collect()
  logic [47:0] got_key [16];
  logic [3:0]  got_idx [16];
  int   n_hs, n_done, n_unstable, gaps, first_valid, done_cyc;
  logic busy_at_1, busy_at_done, busy_d1, busy_d2, par_seen, par_at_1;

  // Starts a run from posedge+1 and records every handshake. key_in/decrypt
  // are scrambled after the start edge. restart_at pulses start once when
  // that many handshakes are recorded. hold drives start in the done cycle
  // and the cycle after it, with the original key/direction.
  task automatic collect(input logic [63:0] key, input logic dec, input logic rnd,
                         input int restart_at, input logic hold);
    logic [47:0] pk;
    logic [3:0]  pi;
    logic        pstall, restarted, seen;
    n_hs = 0; n_done = 0; n_unstable = 0; gaps = 0; first_valid = -1; done_cyc = -1;
    busy_at_1 = 1'b0; busy_at_done = 1'b1; busy_d1 = 1'b1; busy_d2 = 1'b0;
    par_seen = 1'b0; par_at_1 = 1'b1;
    pk = '0; pi = '0; pstall = 1'b0; restarted = 1'b0; seen = 1'b0;
    key_in = key; decrypt = dec; start = 1'b1;
    subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      key_in = ~key; decrypt = ~dec; start = 1'b0;
      if (cyc == 1) begin busy_at_1 = busy; par_at_1 = parity_err; end
      if (parity_err) par_seen = 1'b1;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
      end
      if (subkey_valid && first_valid < 0) first_valid = cyc;
      if (pstall && (!subkey_valid || subkey !== pk || round_idx !== pi)) n_unstable++;
      if (seen && !subkey_valid && n_hs < 16) gaps++;
      if (subkey_valid) seen = 1'b1;
      if (restart_at >= 0 && n_hs == restart_at && !restarted) begin
        start = 1'b1; restarted = 1'b1;
      end
      if (hold && done_cyc > 0) begin
        if (cyc == done_cyc + 1) busy_d1 = busy;
        if (cyc == done_cyc + 2) busy_d2 = busy;
        if (cyc <= done_cyc + 1) begin start = 1'b1; key_in = key; decrypt = dec; end
      end
      subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (subkey_valid && subkey_ready) begin
        if (n_hs < 16) begin got_key[n_hs] = subkey; got_idx[n_hs] = round_idx; end
        n_hs++;
        pstall = 1'b0;
      end else begin
        pstall = subkey_valid; pk = subkey; pi = round_idx;
      end
      if (done_cyc > 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0; key_in = key; decrypt = dec;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; subkey_ready = 1'b0; key_in = '0; decrypt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (subkey_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", subkey_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (subkey !== 48'h0) begin bad++; $display("FAIL reset_subkey got=%h want=0", subkey); end
    total++; if (round_idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", round_idx); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b want=0", parity_err); end
    reset = 1'b0;
  endtask

  task automatic test_encrypt;
    collect(KEY_T1, 1'b0, 1'b0, -1, 1'b0);
    total++; if (n_hs !== 16) begin bad++; $display("FAIL enc_count got=%0d want=16", n_hs); end
    total++; if (first_valid !== 2) begin bad++; $display("FAIL enc_latency got=%0d want=2", first_valid); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL enc_gaps got=%0d want=0", gaps); end
    total++; if (busy_at_1 !== 1'b1) begin bad++; $display("FAIL enc_busy got=%b want=1", busy_at_1); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL enc_done_count got=%0d want=1", n_done); end
    total++; if (done_cyc !== 18) begin bad++; $display("FAIL enc_done_cycle got=%0d want=18", done_cyc); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL enc_busy_at_done got=%b want=0", busy_at_done); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_key[i] !== EXP_K[i]) begin bad++; $display("FAIL enc_key[%0d] got=%h want=%h", i, got_key[i], EXP_K[i]); end
      total++; if (got_idx[i] !== 4'(i)) begin bad++; $display("FAIL enc_idx[%0d] got=%0d want=%0d", i, got_idx[i], i); end
    end
  endtask

  task automatic test_decrypt;
    collect(KEY_T1, 1'b1, 1'b0, -1, 1'b0);
    total++; if (n_hs !== 16) begin bad++; $display("FAIL dec_count got=%0d want=16", n_hs); end
    total++; if (first_valid !== 2) begin bad++; $display("FAIL dec_latency got=%0d want=2", first_valid); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL dec_done_count got=%0d want=1", n_done); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_key[i] !== EXP_K[15-i]) begin bad++; $display("FAIL dec_key[%0d] got=%h want=%h", i, got_key[i], EXP_K[15-i]); end
      total++; if (got_idx[i] !== 4'(15-i)) begin bad++; $display("FAIL dec_idx[%0d] got=%0d want=%0d", i, got_idx[i], 15-i); end
    end
  endtask

  task automatic test_backpressure;
    collect(KEY_T1, 1'b0, 1'b1, -1, 1'b0);
    total++; if (n_hs !== 16) begin bad++; $display("FAIL bp_count got=%0d want=16", n_hs); end
    total++; if (n_unstable !== 0) begin bad++; $display("FAIL bp_stall_changes got=%0d want=0", n_unstable); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL bp_gaps got=%0d want=0", gaps); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL bp_done_count got=%0d want=1", n_done); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_key[i] !== EXP_K[i]) begin bad++; $display("FAIL bp_key[%0d] got=%h want=%h", i, got_key[i], EXP_K[i]); end
      total++; if (got_idx[i] !== 4'(i)) begin bad++; $display("FAIL bp_idx[%0d] got=%0d want=%0d", i, got_idx[i], i); end
    end
  endtask

  task automatic test_start_while_busy;
    collect(KEY_T1, 1'b0, 1'b0, 5, 1'b1);
    total++; if (n_hs !== 16) begin bad++; $display("FAIL sb_count got=%0d want=16", n_hs); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL sb_done_count got=%0d want=1", n_done); end
    total++; if (done_cyc !== 18) begin bad++; $display("FAIL sb_done_cycle got=%0d want=18", done_cyc); end
    total++; if (busy_d1 !== 1'b0) begin bad++; $display("FAIL sb_start_in_done_cycle busy got=%b want=0", busy_d1); end
    total++; if (busy_d2 !== 1'b1) begin bad++; $display("FAIL sb_start_after_done busy got=%b want=1", busy_d2); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_key[i] !== EXP_K[i]) begin bad++; $display("FAIL sb_key[%0d] got=%h want=%h", i, got_key[i], EXP_K[i]); end
    end
    // Drain the run accepted after done; the start pulse here lands while busy.
    collect(KEY_BADPAR, 1'b1, 1'b0, -1, 1'b0);
    total++; if (n_hs !== 16) begin bad++; $display("FAIL sb2_count got=%0d want=16", n_hs); end
    total++; if (first_valid !== 1) begin bad++; $display("FAIL sb2_first_valid got=%0d want=1", first_valid); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_key[i] !== EXP_K[i]) begin bad++; $display("FAIL sb2_key[%0d] got=%h want=%h", i, got_key[i], EXP_K[i]); end
    end
  endtask

  task automatic test_midrun_reset;
    int done_seen;
    done_seen = 0;
    key_in = KEY_T1; decrypt = 1'b0; subkey_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    // Seven handshakes done; K8 is on the bus.
    total++; if (round_idx !== 4'd7) begin bad++; $display("FAIL mr_idx_before got=%0d want=7", round_idx); end
    total++; if (subkey !== EXP_K[7]) begin bad++; $display("FAIL mr_key_before got=%h want=%h", subkey, EXP_K[7]); end
    reset = 1'b1;
    #1;
    total++; if (subkey_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b want=0", subkey_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b want=0", busy); end
    total++; if (subkey !== 48'h0) begin bad++; $display("FAIL mr_subkey got=%h want=0", subkey); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL mr_done got=%0d want=0", done_seen); end
    reset = 1'b0;
    collect(KEY_T1, 1'b0, 1'b0, -1, 1'b0);
    total++; if (n_hs !== 16) begin bad++; $display("FAIL mr_restart_count got=%0d want=16", n_hs); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_key[i] !== EXP_K[i]) begin bad++; $display("FAIL mr_key[%0d] got=%h want=%h", i, got_key[i], EXP_K[i]); end
    end
  endtask

  task automatic test_parity;
`ifdef KEY_PARITY_CHECK_EN
    key_in = KEY_BADPAR; decrypt = 1'b0; subkey_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err_set got=%b want=1", parity_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL par_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    total++; if (subkey_valid !== 1'b0) begin bad++; $display("FAIL par_valid got=%b want=0", subkey_valid); end
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err_hold got=%b want=1", parity_err); end
    collect(KEY_T1, 1'b0, 1'b0, -1, 1'b0);
    total++; if (par_at_1 !== 1'b0) begin bad++; $display("FAIL par_err_clear got=%b want=0", par_at_1); end
`else
    // Without the check the parity bit is simply dropped by PC-1.
    collect(KEY_BADPAR, 1'b0, 1'b0, -1, 1'b0);
    total++; if (par_seen !== 1'b0) begin bad++; $display("FAIL par_tied got=%b want=0", par_seen); end
`endif
    total++; if (n_hs !== 16) begin bad++; $display("FAIL par_count got=%0d want=16", n_hs); end
    for (int i = 0; i < 16; i++) begin
      total++; if (got_key[i] !== EXP_K[i]) begin bad++; $display("FAIL par_key[%0d] got=%h want=%h", i, got_key[i], EXP_K[i]); end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_start_while_busy();
    test_midrun_reset();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
